fifo_rd_ctrl: RTL and testbench
===============================

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width.
REQ-002 SHALL have parameter MEM_DEPTH, default 64, memory depth, power of two.
REQ-003 SHALL have parameter ADDR_BITS, default $clog2(MEM_DEPTH), memory address width.
REQ-004 SHALL have port i_clk  in  1  read-domain clock; the block uses one clock only.
REQ-005 SHALL have port i_reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_wr_ptr_gray  in  ADDR_BITS+1  write pointer, Gray-coded, already synchronised into i_clk.
REQ-007 SHALL have port o_rd_ptr_gray  out  ADDR_BITS+1  registered Gray read pointer, for the write domain.
REQ-008 SHALL have port o_rd_addr  out  ADDR_BITS  memory read address.
REQ-009 SHALL have port o_rd_en  out  1  read-issue strobe to memory.
REQ-010 SHALL have port i_mem_data  in  DATA_WIDTH  registered memory output, valid one cycle after address.
REQ-011 SHALL have port o_data  out  DATA_WIDTH  stream data.
REQ-012 SHALL have port o_valid  out  1  stream valid.
REQ-013 SHALL have port i_ready  in  1  stream ready from consumer.
REQ-014 SHALL have port o_empty  out  1  high when memory and output buffer hold no words.
REQ-015 SHALL have port o_occupancy  out  ADDR_BITS+1  words held in memory (see Configuration).

Function
REQ-016 SHALL keep binary read pointer rd_ptr (ADDR_BITS+1 bits, wraps modulo 2*MEM_DEPTH); o_rd_addr = rd_ptr[ADDR_BITS-1:0]; o_rd_ptr_gray = registered bin2gray(rd_ptr).
REQ-017 SHALL flag mem_empty when bin2gray(rd_ptr) == i_wr_ptr_gray.
REQ-018 SHALL hold a 2-entry output buffer; credits = 2 - (buffered words + reads in flight).
REQ-019 SHALL issue a read (o_rd_en=1, rd_ptr+1 at clock edge) only when !mem_empty and credits > 0 counting a same-cycle pop.
REQ-020 SHALL capture i_mem_data into the buffer in the cycle after a read issue; memory-to-o_valid latency = 2 cycles.
REQ-021 SHALL present the oldest buffered word on o_data with o_valid=1; pop on o_valid && i_ready.
REQ-022 SHALL hold o_data stable while o_valid=1 and i_ready=0.
REQ-023 SHALL sustain one word per cycle with i_ready held high and memory non-empty.
REQ-024 SHALL support simultaneous capture and pop: buffer count unchanged, order preserved.
REQ-025 SHALL never read past the write pointer; an empty-to-non-empty transition issues a read in the same cycle it is seen.
REQ-026 SHALL drive o_empty = mem_empty && no word buffered && none in flight.
REQ-027 SHALL have pointer wrap from 2*MEM_DEPTH-1 to 0 without data loss.

Reset
REQ-028 SHALL on i_reset_n=0 asynchronously clear rd_ptr, o_rd_ptr_gray, o_rd_addr, buffer, in-flight flag and o_occupancy to 0; o_valid=0, o_rd_en=0, o_empty=1.
REQ-029 SHALL discard all buffered and in-flight words on reset mid-transfer; the first word after release comes from address 0.

Configuration
REQ-030 SHALL, when macro FIFO_RD_OCCUPANCY_EN is defined, register o_occupancy = gray2bin(i_wr_ptr_gray) - rd_ptr (modulo 2^(ADDR_BITS+1)), updated every cycle.
REQ-031 SHALL, when FIFO_RD_OCCUPANCY_EN is undefined, tie o_occupancy to 0 and infer no gray2bin logic.

Verification (MEM_DEPTH=8)
REQ-032 SHALL cover: reset release, wr_ptr_gray=0 -> o_empty=1, o_valid=0, o_rd_en=0.
REQ-033 SHALL cover: wr_ptr_gray 0->1 (binary 1), i_ready=1 -> o_rd_en=1 at addr 0; o_valid=1 two cycles later; rd_ptr_gray=1; o_empty=1 after pop.
REQ-034 SHALL cover: 8 words preloaded, i_ready=0 -> exactly 2 reads issued, o_data=word0 held; i_ready=1 -> words 0..7 on 8 consecutive cycles.
REQ-035 SHALL cover: 20 words streamed through a depth-8 memory, crossing rd_ptr 15->0 -> all 20 words in order.
REQ-036 SHALL cover: reset asserted with 2 words buffered -> o_valid=0 immediately, rd_ptr=0.
REQ-037 SHALL cover: with FIFO_RD_OCCUPANCY_EN, wr_ptr binary 5, rd_ptr 2 -> o_occupancy=3; without the macro -> o_occupancy=0.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: async-FIFO read side with a 2-entry skid buffer; FIFO_RD_OCCUPANCY_EN adds a registered occupancy count.
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 64,
  parameter int ADDR_BITS  = $clog2(MEM_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [ADDR_BITS:0]    i_wr_ptr_gray,
  output logic [ADDR_BITS:0]    o_rd_ptr_gray,
  output logic [ADDR_BITS-1:0]  o_rd_addr,
  output logic                  o_rd_en,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_empty,
  output logic [ADDR_BITS:0]    o_occupancy
);
  localparam int PW = ADDR_BITS + 1;
  logic [PW-1:0] rd_ptr, rd_ptr_nxt;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [1:0] cnt, load;
  logic in_flight, mem_empty, pop, issue, wr_idx;
  assign mem_empty  = (rd_ptr ^ (rd_ptr >> 1)) == i_wr_ptr_gray;
  assign o_valid    = cnt != 2'd0;
  assign pop        = o_valid && i_ready;
  // slots committed after this edge, not counting a new issue
  assign load       = cnt + 2'(in_flight) - 2'(pop);
  assign issue      = i_reset_n && !mem_empty && load < 2'd2;
  assign rd_ptr_nxt = rd_ptr + PW'(issue);
  assign wr_idx     = (cnt - 2'(pop)) != 2'd0;
  assign o_rd_en    = issue;
  assign o_rd_addr  = rd_ptr[ADDR_BITS-1:0];
  assign o_data     = buf_q[0];
  assign o_empty    = mem_empty && cnt == 2'd0 && !in_flight;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr        <= '0;
      o_rd_ptr_gray <= '0;
      in_flight     <= 1'b0;
      cnt           <= 2'd0;
      buf_q[0]      <= '0;
      buf_q[1]      <= '0;
    end else begin
      rd_ptr        <= rd_ptr_nxt;
      o_rd_ptr_gray <= rd_ptr_nxt ^ (rd_ptr_nxt >> 1);
      in_flight     <= issue;
      cnt           <= load;
      if (pop) buf_q[0] <= buf_q[1];
      if (in_flight) buf_q[wr_idx] <= i_mem_data;
    end
  end
`ifdef FIFO_RD_OCCUPANCY_EN
  logic [PW-1:0] wr_bin;
  for (genvar g = 0; g < PW; g++) begin : g_g2b
    assign wr_bin[g] = ^(i_wr_ptr_gray >> g);
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) o_occupancy <= '0;
    else o_occupancy <= wr_bin - rd_ptr;
  end
`else
  assign o_occupancy = '0;
`endif
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: randomized scoreboard bench for fifo_rd_ctrl at MEM_DEPTH=8.
module tb_fifo_rd_ctrl;
  localparam int DW = 8, D = 8, AB = 3, PW = 4;
  logic i_clk = 1'b0, i_reset_n = 1'b0, i_ready = 1'b0;
  logic [PW-1:0] i_wr_ptr_gray = '0, o_rd_ptr_gray, o_occupancy;
  logic [AB-1:0] o_rd_addr;
  logic o_rd_en, o_valid, o_empty;
  logic [DW-1:0] i_mem_data = '0, o_data;
  logic [DW-1:0] mem [D];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] hold_data;
  logic [PW-1:0] prev_occ = '0;
  logic hold_pend = 1'b0;
  int n_vec = 0, n_err = 0, n_wr = 0, n_rd = 0, n_pop = 0;

  fifo_rd_ctrl #(.DATA_WIDTH(DW), .MEM_DEPTH(D)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_wr_ptr_gray(i_wr_ptr_gray),
    .o_rd_ptr_gray(o_rd_ptr_gray), .o_rd_addr(o_rd_addr), .o_rd_en(o_rd_en),
    .i_mem_data(i_mem_data), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_empty(o_empty), .o_occupancy(o_occupancy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) if (o_rd_en) i_mem_data <= mem[o_rd_addr];

  function automatic logic [PW-1:0] gray(int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr_word(logic [DW-1:0] d);
    mem[n_wr % D] = d;
    exp_q.push_back(d);
    n_wr++;
    i_wr_ptr_gray = gray(n_wr);
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  // Scoreboard: every word leaves in write order, no read beyond what was written
  always @(negedge i_clk) begin
    if (i_reset_n) begin
      check("empty", o_empty, n_wr == n_pop);
      check("rd_gray", o_rd_ptr_gray, gray(n_rd));
      check("rd_addr", o_rd_addr, n_rd % D);
      check("overread", o_rd_en && n_rd >= n_wr, 0);
      check("valid_unbacked", o_valid && exp_q.size() == 0, 0);
      if (hold_pend) check("hold", {o_valid, o_data}, {1'b1, hold_data});
`ifdef FIFO_RD_OCCUPANCY_EN
      check("occ", o_occupancy, prev_occ);
`else
      check("occ", o_occupancy, 0);
`endif
      prev_occ = PW'(n_wr - n_rd);
      if (o_valid && i_ready) begin
        check("pop_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("data", o_data, exp_q.pop_front());
        n_pop++;
      end
      hold_pend = o_valid && !i_ready;
      hold_data = o_data;
      if (o_rd_en) n_rd++;
    end
  end

  initial begin
    int base;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_empty", o_empty, 1);
    check("rst_valid", o_valid, 0);
    check("rst_rden", o_rd_en, 0);
    check("rst_gray", o_rd_ptr_gray, 0);
    check("rst_occ", o_occupancy, 0);
    i_reset_n = 1'b1;
    repeat (3) cyc();
    check("idle_empty", o_empty, 1);
    check("idle_rden", o_rd_en, 0);
    // single word: issue same cycle, valid two cycles later
    i_ready = 1'b1;
    wr_word(8'hA5);
    @(negedge i_clk);
    check("t1_rden", o_rd_en, 1);
    check("t1_addr", o_rd_addr, 0);
    @(negedge i_clk);
    check("t1_valid_lat1", o_valid, 0);
    @(negedge i_clk);
    check("t1_valid", o_valid, 1);
    check("t1_data", o_data, 8'hA5);
    @(negedge i_clk);
    check("t1_empty", o_empty, 1);
    check("t1_gray", o_rd_ptr_gray, 1);
    // preload 8 with consumer stalled
    cyc();
    i_ready = 1'b0;
    base = n_rd;
    for (int i = 0; i < 8; i++) begin
      wr_word(DW'(8'h10 + i));
      cyc();
    end
    repeat (4) cyc();
    check("pre_reads", n_rd - base, 2);
    check("pre_valid", o_valid, 1);
    check("pre_data", o_data, 8'h10);
    i_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      check("burst_valid", o_valid, 1);
    end
    cyc();
    check("burst_drained", exp_q.size(), 0);
    // 20 words streamed across the pointer wrap
    for (int i = 0; i < 40; i++) begin
      if (n_wr - n_rd < D && n_wr < 29) wr_word(DW'($urandom));
      cyc();
    end
    check("wrap_drained", exp_q.size(), 0);
    check("wrap_count", n_wr, 29);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      i_ready = $urandom_range(0, 3) != 0;
      if (n_wr - n_rd < D && $urandom_range(0, 1) == 1) wr_word(DW'($urandom));
      cyc();
    end
    i_ready = 1'b1;
    repeat (20) cyc();
    check("rand_drained", exp_q.size(), 0);
    // reset with words buffered
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (n_wr - n_rd < D) wr_word(DW'($urandom));
      cyc();
    end
    repeat (3) cyc();
    check("mid_valid", o_valid, 1);
    #1;
    i_reset_n = 1'b0;
    #1;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_rden", o_rd_en, 0);
    check("mid_rst_gray", o_rd_ptr_gray, 0);
    check("mid_rst_addr", o_rd_addr, 0);
    i_wr_ptr_gray = '0;
    n_wr = 0; n_rd = 0; n_pop = 0;
    exp_q.delete();
    hold_pend = 1'b0;
    prev_occ = '0;
    cyc();
    check("mid_rst_empty", o_empty, 1);
    i_reset_n = 1'b1;
    cyc();
    // occupancy: 5 written, 2 read
    for (int i = 0; i < 5; i++) begin
      wr_word(DW'(8'h50 + i));
      if (i == 0) begin
        @(negedge i_clk);
        check("post_rst_addr", o_rd_addr, 0);
        check("post_rst_rden", o_rd_en, 1);
      end
      cyc();
    end
    repeat (3) cyc();
    check("occ_reads", n_rd, 2);
    check("occ_data", o_data, 8'h50);
`ifdef FIFO_RD_OCCUPANCY_EN
    check("occ_value", o_occupancy, 3);
`else
    check("occ_value", o_occupancy, 0);
`endif
    i_ready = 1'b1;
    repeat (12) cyc();
    check("final_drained", exp_q.size(), 0);
    check("final_empty", o_empty, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
